// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the Sobel gradient-magnitude pipeline.
// Latency: n/a (package). Backpressure: n/a.
// Contents: window pixel indices, partial-sum slot indices, width helpers, saturation.
package sobel_pkg;

  // Pixel positions inside the row-major 3x3 window (p00 in the LSBs).
  localparam int P00 = 0;
  localparam int P01 = 1;
  localparam int P02 = 2;
  localparam int P10 = 3;
  localparam int P11 = 4;
  localparam int P12 = 5;
  localparam int P20 = 6;
  localparam int P21 = 7;
  localparam int P22 = 8;

  // Slots of the four weighted partial sums formed in stage 1.
  localparam int SUM_RIGHT  = 0;
  localparam int SUM_LEFT   = 1;
  localparam int SUM_BOTTOM = 2;
  localparam int SUM_TOP    = 3;
  localparam int NUM_SUMS   = 4;

  // A 1-2-1 weighted sum of three pixels is at most 4*(2^w-1).
  function automatic int sum_width(input int w);
    return w + 2;
  endfunction

  // Difference of two such sums, signed, with the sign bit on top.
  function automatic int diff_width(input int w);
    return w + 3;
  endfunction

  // Clamp an unsigned value to the largest w-bit pixel.
  function automatic logic [31:0] sat_pixel(input logic [31:0] value, input int w);
    logic [31:0] max_pix;
    max_pix = (32'd1 << w) - 32'd1;
    return (value > max_pix) ? max_pix : value;
  endfunction

endpackage

// File: rtl/add.sv
// Ripple carry-chain adder: sum_o = a_i + b_i + cin_i, carry-out discarded.
// Latency: combinational. Backpressure: n/a.
// Ports: a_i, b_i (WIDTH), cin_i (1) in; sum_o (WIDTH) out.
module add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o
);

  // carry[i] is the carry into bit i.
  logic [WIDTH-1:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ carry[i];
    if (i < WIDTH - 1) begin : g_carry
      assign carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

endmodule

// File: rtl/sobel_abs.sv
// Absolute value of a two's complement number via a conditional negate.
// Latency: combinational. Backpressure: n/a.
// Ports: value (WIDTH, signed) in; magnitude (WIDTH, unsigned) out.
module sobel_abs #(
  parameter int WIDTH = 11
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] magnitude
);

  logic             negative;
  logic [WIDTH-1:0] flipped;

  // Negative: ~x + 1. Positive: x ^ 0 + 0, i.e. a pass-through.
  assign negative = value[WIDTH-1];
  assign flipped  = value ^ {WIDTH{negative}};

  add #(.WIDTH(WIDTH)) u_negate (
    .a_i  (flipped),
    .b_i  ({WIDTH{1'b0}}),
    .cin_i(negative),
    .sum_o(magnitude)
  );

endmodule

// File: rtl/sobel_mag.sv
// Sobel gradient magnitude: one 3x3 window in, saturated |Gx|+|Gy| pixel out.
// Latency: 3 cycles accept-to-valid_o; one window per cycle when ready_i=1.
// Backpressure: valid/ready enable chain; empty stages fill under a stall,
//   ready_o drops combinationally only when all three stages hold data and ready_i=0.
// Ports: clk_i, reset_i (async, active-high); valid_i/ready_o/window_i upstream;
//   valid_o/ready_i/mag_o downstream.
module sobel_mag
  import sobel_pkg::*;
#(
  parameter int WIDTH_P = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [9*WIDTH_P-1:0] window_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [WIDTH_P-1:0]   mag_o
);

  localparam int SW = sum_width(WIDTH_P);
  localparam int DW = diff_width(WIDTH_P);

  // ---------------- pipeline control ----------------
  logic v1, v2, v3;
  logic en1, en2, en3;

  assign en3     = !v3 | ready_i;
  assign en2     = !v2 | en3;
  assign en1     = !v1 | en2;
  assign ready_o = en1;

  // ---------------- stage 1: weighted column/row sums ----------------
  logic [WIDTH_P-1:0] p00, p01, p02, p10, p12, p20, p21, p22;
  logic               unused_center;

  assign p00 = window_i[P00*WIDTH_P +: WIDTH_P];
  assign p01 = window_i[P01*WIDTH_P +: WIDTH_P];
  assign p02 = window_i[P02*WIDTH_P +: WIDTH_P];
  assign p10 = window_i[P10*WIDTH_P +: WIDTH_P];
  assign p12 = window_i[P12*WIDTH_P +: WIDTH_P];
  assign p20 = window_i[P20*WIDTH_P +: WIDTH_P];
  assign p21 = window_i[P21*WIDTH_P +: WIDTH_P];
  assign p22 = window_i[P22*WIDTH_P +: WIDTH_P];
  // The centre pixel has zero weight in both kernels.
  assign unused_center = ^window_i[P11*WIDTH_P +: WIDTH_P];

  // Each partial sum = (end + end) + 2*middle.
  logic [SW-1:0] end_a [NUM_SUMS];
  logic [SW-1:0] end_b [NUM_SUMS];
  logic [SW-1:0] mid2  [NUM_SUMS];
  logic [SW-1:0] ends  [NUM_SUMS];
  logic [SW-1:0] psum  [NUM_SUMS];

  assign end_a[SUM_RIGHT]  = {2'b00, p02};
  assign end_b[SUM_RIGHT]  = {2'b00, p22};
  assign mid2[SUM_RIGHT]   = {1'b0, p12, 1'b0};
  assign end_a[SUM_LEFT]   = {2'b00, p00};
  assign end_b[SUM_LEFT]   = {2'b00, p20};
  assign mid2[SUM_LEFT]    = {1'b0, p10, 1'b0};
  assign end_a[SUM_BOTTOM] = {2'b00, p20};
  assign end_b[SUM_BOTTOM] = {2'b00, p22};
  assign mid2[SUM_BOTTOM]  = {1'b0, p21, 1'b0};
  assign end_a[SUM_TOP]    = {2'b00, p00};
  assign end_b[SUM_TOP]    = {2'b00, p02};
  assign mid2[SUM_TOP]     = {1'b0, p01, 1'b0};

  for (genvar k = 0; k < NUM_SUMS; k++) begin : g_psum
    add #(.WIDTH(SW)) u_ends (
      .a_i  (end_a[k]),
      .b_i  (end_b[k]),
      .cin_i(1'b0),
      .sum_o(ends[k])
    );
    add #(.WIDTH(SW)) u_mid (
      .a_i  (ends[k]),
      .b_i  (mid2[k]),
      .cin_i(1'b0),
      .sum_o(psum[k])
    );
  end

  logic [SW-1:0] s1_sum [NUM_SUMS];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v1 <= 1'b0;
      for (int k = 0; k < NUM_SUMS; k++) s1_sum[k] <= '0;
    end else if (en1) begin
      v1 <= valid_i;
      for (int k = 0; k < NUM_SUMS; k++) s1_sum[k] <= psum[k];
    end
  end

  // ---------------- stage 2: signed gradients and their magnitudes ----------------
  logic [DW-1:0] gx, gy, abs_gx, abs_gy;

  // a - b as a + ~b + 1, both operands zero-extended so the top bit is the sign.
  add #(.WIDTH(DW)) u_gx (
    .a_i  ({1'b0, s1_sum[SUM_RIGHT]}),
    .b_i  (~{1'b0, s1_sum[SUM_LEFT]}),
    .cin_i(1'b1),
    .sum_o(gx)
  );

  add #(.WIDTH(DW)) u_gy (
    .a_i  ({1'b0, s1_sum[SUM_BOTTOM]}),
    .b_i  (~{1'b0, s1_sum[SUM_TOP]}),
    .cin_i(1'b1),
    .sum_o(gy)
  );

  sobel_abs #(.WIDTH(DW)) u_abs_gx (.value(gx), .magnitude(abs_gx));
  sobel_abs #(.WIDTH(DW)) u_abs_gy (.value(gy), .magnitude(abs_gy));

  logic [DW-1:0] s2_abs_gx, s2_abs_gy;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v2        <= 1'b0;
      s2_abs_gx <= '0;
      s2_abs_gy <= '0;
    end else if (en2) begin
      v2        <= v1;
      s2_abs_gx <= abs_gx;
      s2_abs_gy <= abs_gy;
    end
  end

  // ---------------- stage 3: L1 magnitude with saturation ----------------
  logic [DW-1:0]      l1_sum;
  logic [WIDTH_P-1:0] l1_sat;

  add #(.WIDTH(DW)) u_l1 (
    .a_i  (s2_abs_gx),
    .b_i  (s2_abs_gy),
    .cin_i(1'b0),
    .sum_o(l1_sum)
  );

  assign l1_sat = WIDTH_P'(sat_pixel(32'(l1_sum), WIDTH_P));

  logic [WIDTH_P-1:0] s3_mag;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v3     <= 1'b0;
      s3_mag <= '0;
    end else if (en3) begin
      v3     <= v2;
      s3_mag <= l1_sat;
    end
  end

  assign valid_o = v3;
  assign mag_o   = s3_mag;

endmodule

// File: tb/tb_sobel_mag.sv
// Self-checking bench for sobel_mag (WIDTH_P=8): directed windows, latency,
// backpressure, random traffic against an arithmetic reference, mid-stream reset.
module tb_sobel_mag;

  localparam int W = 8;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic           valid_i;
  logic           ready_o;
  logic [9*W-1:0] window_i;
  logic           valid_o;
  logic           ready_i;
  logic [W-1:0]   mag_o;

  sobel_mag #(.WIDTH_P(W)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .window_i(window_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .mag_o   (mag_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int q[$];                 // expected results of accepted, undelivered windows
  int last_acc_cyc = -1;
  int last_del_cyc = -1;
  logic acc_flag = 1'b0;
  logic rdy_low_seen = 1'b0;
  logic prev_stall = 1'b0;
  logic [W-1:0] prev_mag = '0;
  logic [9*W-1:0] idle_w = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: Sobel kernels evaluated with plain integers.
  function automatic int ref_mag(input logic [9*W-1:0] w);
    int p[9];
    int gx, gy, m;
    for (int i = 0; i < 9; i++) p[i] = int'(w[i*W +: W]);
    gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  function automatic logic [9*W-1:0] mk(input int a00, a01, a02, a10, a11, a12, a20, a21, a22);
    return {8'(a22), 8'(a21), 8'(a20), 8'(a12), 8'(a11), 8'(a10), 8'(a02), 8'(a01), 8'(a00)};
  endfunction

  // One clock cycle: drive, sample mid-cycle, check, then advance past the edge.
  task automatic step(input logic v, input logic [9*W-1:0] w, input int e, input logic r);
    logic exp_rdy;
    valid_i  = v;
    window_i = w;
    ready_i  = r;
    #3;
    if (prev_stall) begin
      check("stall_valid", 32'(valid_o), 1);
      check("stall_mag", 32'(mag_o), 32'(prev_mag));
    end
    exp_rdy = !(q.size() == 3 && !r);
    check("ready_o", 32'(ready_o), 32'(exp_rdy));
    if (ready_o === 1'b0) rdy_low_seen = 1'b1;
    check("no_spurious", 32'(valid_o && q.size() == 0), 0);
    if (valid_o && r && q.size() > 0) begin
      check("mag", 32'(mag_o), q.pop_front());
      last_del_cyc = cyc;
    end
    prev_stall = valid_o && !r;
    prev_mag   = mag_o;
    acc_flag   = v && ready_o;
    if (acc_flag) begin
      q.push_back(e);
      last_acc_cyc = cyc;
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, idle_w, 0, 1'b1);
    check({tag, "_drained"}, q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9*W-1:0] bp[6];
    logic [9*W-1:0] rw, wa, wb, wc;
    int acc, sent;

    reset_i  = 1'b1;
    valid_i  = 1'b0;
    ready_i  = 1'b1;
    window_i = '0;

    // Reset state, asserted before any clock edge.
    #2;
    check("rst_valid_o", 32'(valid_o), 0);
    check("rst_mag_o", 32'(mag_o), 0);
    check("rst_ready_o", 32'(ready_o), 1);
    #11;
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("post_rst_ready_o", 32'(ready_o), 1);
    check("post_rst_valid_o", 32'(valid_o), 0);

    // Flat window: zero gradient, three-cycle latency.
    step(1'b1, mk(100, 100, 100, 100, 100, 100, 100, 100, 100), 0, 1'b1);
    acc = last_acc_cyc;
    for (int i = 0; i < 10 && last_del_cyc < acc; i++) step(1'b0, idle_w, 0, 1'b1);
    check("latency", 32'(last_del_cyc - acc), 3);

    // Vertical edge, negative vertical gradient, saturation, back-to-back.
    step(1'b1, mk(0, 0, 10, 0, 0, 10, 0, 0, 10), 40, 1'b1);
    step(1'b1, mk(50, 50, 50, 0, 0, 0, 0, 0, 0), 200, 1'b1);
    step(1'b1, mk(0, 0, 255, 0, 0, 255, 0, 255, 255), 255, 1'b1);
    drain("directed");

    // Backpressure: six distinct windows, ready_i low on cycles 2..6.
    for (int k = 0; k < 6; k++) bp[k] = mk(0, k, 10*(k+1), 0, 0, 10*(k+1), 0, 0, 10*(k+1));
    sent = 0;
    rdy_low_seen = 1'b0;
    for (int i = 1; i <= 40 && (sent < 6 || q.size() > 0); i++) begin
      if (sent < 6) step(1'b1, bp[sent], ref_mag(bp[sent]), !(i >= 2 && i <= 6));
      else          step(1'b0, idle_w, 0, !(i >= 2 && i <= 6));
      if (acc_flag) sent++;
    end
    check("bp_sent", sent, 6);
    check("bp_ready_dropped", 32'(rdy_low_seen), 1);
    check("bp_drained", q.size(), 0);

    // Random traffic with random stalls.
    for (int i = 0; i < 400; i++) begin
      rw[31:0]  = $urandom();
      rw[63:32] = $urandom();
      rw[71:64] = 8'($urandom());
      step($urandom_range(0, 3) != 0, rw, ref_mag(rw), $urandom_range(0, 3) != 0);
    end
    drain("random");

    // Mid-stream reset with two windows in flight.
    wa = mk(0, 0, 30, 0, 0, 30, 0, 0, 30);
    wb = mk(20, 20, 20, 0, 0, 0, 0, 0, 0);
    wc = mk(0, 0, 0, 0, 0, 0, 7, 7, 7);
    step(1'b0, wa, 0, 1'b1);
    step(1'b0, wa, 0, 1'b1);
    step(1'b1, wa, 120, 1'b1);
    step(1'b1, wb, 80, 1'b1);
    valid_i = 1'b0;
    #1;
    reset_i = 1'b1;
    #1;
    check("midrst_valid_o", 32'(valid_o), 0);
    check("midrst_mag_o", 32'(mag_o), 0);
    check("midrst_ready_o", 32'(ready_o), 1);
    q.delete();
    prev_stall = 1'b0;
    @(posedge clk_i);
    #3;
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 6; i++) step(1'b0, idle_w, 0, 1'b1);
    last_del_cyc = -1;
    step(1'b1, wc, 28, 1'b1);
    drain("post_reset");
    check("post_reset_delivered", 32'(last_del_cyc >= 0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
